// File: rtl/rr_io_arbiter_if.sv
// Channel-side request bus and single-port memory bus of the round-robin IO arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface rr_io_arbiter_if #(
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = 64,
    parameter int CH_COUNT  = 4
);
    logic [CH_COUNT-1:0]           req;
    logic [CH_COUNT-1:0]           dir;
    logic [CH_COUNT*ADDR_SIZE-1:0] addr_in;
    logic [CH_COUNT*WORD_SIZE-1:0] wdata_in;
    logic [CH_COUNT-1:0]           gnt;
    logic [CH_COUNT-1:0]           done;
    logic [CH_COUNT-1:0]           err;
    logic [WORD_SIZE-1:0]          rdata_out;
    logic                          mem_req;
    logic                          mem_dir;
    logic [ADDR_SIZE-1:0]          mem_add;
    logic [WORD_SIZE-1:0]          mem_wdata;
    logic [WORD_SIZE-1:0]          mem_rdata;
    logic                          mem_ack;

    modport slave (
        input  req, dir, addr_in, wdata_in, mem_rdata, mem_ack,
        output gnt, done, err, rdata_out,
        output mem_req, mem_dir, mem_add, mem_wdata
    );

    modport master (
        output req, dir, addr_in, wdata_in, mem_rdata, mem_ack,
        input  gnt, done, err, rdata_out,
        input  mem_req, mem_dir, mem_add, mem_wdata
    );
endinterface

// File: rtl/rr_io_arbiter.sv
// Round-robin arbiter sharing one memory port among CH_COUNT IO channels.
// IDLE -> BUSY -> RESP per transaction, with an optional BUSY timeout.
module rr_io_arbiter #(
    parameter int WORD_SIZE = 64,
    parameter int ADDR_SIZE = 64,
    parameter int CH_COUNT  = 4,
    parameter int TIMEOUT   = 255
) (
    input logic            clk,
    input logic            rst,
    rr_io_arbiter_if.slave bus
);
    localparam int IW = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CH_COUNT-1:0] ONE = CH_COUNT'(1);
    localparam logic [IW-1:0] TOP = IW'(CH_COUNT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    stateT         state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] curIdx;
    logic [IW-1:0] selIdx;
    logic [CW-1:0] cnt;

    // Scan downward so the channel closest to ptr is the last one written.
    function automatic logic [IW-1:0] pickNext(
        input logic [CH_COUNT-1:0] r,
        input logic [IW-1:0]       p
    );
        logic [IW-1:0] s;
        logic [IW-1:0] c;
        s = p;
        for (int k = CH_COUNT - 1; k >= 0; k--) begin
            c = IW'((int'(p) + k) % CH_COUNT);
            if (r[c]) s = c;
        end
        return s;
    endfunction

    always_comb begin
        selIdx = pickNext(bus.req, ptr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= '0;
            curIdx        <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.rdata_out <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_dir   <= 1'b0;
            bus.mem_add   <= '0;
            bus.mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        curIdx        <= selIdx;
                        bus.mem_add   <= bus.addr_in[selIdx*ADDR_SIZE +: ADDR_SIZE];
                        bus.mem_wdata <= bus.wdata_in[selIdx*WORD_SIZE +: WORD_SIZE];
                        bus.mem_dir   <= bus.dir[selIdx];
                        bus.gnt       <= ONE << selIdx;
                        bus.mem_req   <= 1'b1;
                        cnt           <= '0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_dir) bus.rdata_out <= bus.mem_rdata;
                        bus.done    <= ONE << curIdx;
                        bus.mem_req <= 1'b0;
                        state       <= RESP;
                    end else if (TIMEOUT > 0 && cnt == LAST) begin
                        bus.err     <= ONE << curIdx;
                        bus.mem_req <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    bus.done <= '0;
                    bus.err  <= '0;
                    bus.gnt  <= '0;
                    ptr      <= (curIdx == TOP) ? '0 : curIdx + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
